// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage MIPS core: tracks in-flight destinations,
// drives the forwarding-mux selects and D-stage stall, and sequences the MDU busy window.
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] tuse_rs_D,
    input  logic [1:0] tuse_rt_D,
    input  logic [4:0] wa_D,
    input  logic [1:0] res_D,
    input  logic       md_D,
    input  logic [1:0] md_start_D,
    output logic       stall,
    output logic [3:0] sel_cmp1_D,
    output logic [3:0] sel_cmp2_D,
    output logic [3:0] sel_alua_E,
    output logic [3:0] sel_alub_E,
    output logic [3:0] sel_dm_M,
    output logic       md_busy
);

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_ALU  = 2'd1;
    localparam logic [1:0] RES_DM   = 2'd2;
    localparam logic [1:0] RES_PC   = 2'd3;
    localparam logic [3:0] MULT_CYC = 4'd5;
    localparam logic [3:0] DIV_CYC  = 4'd10;

    logic [4:0] wa_e_q, wa_e_d, rs_e_q, rs_e_d, rt_e_q, rt_e_d;
    logic [1:0] res_e_q, res_e_d, tnew_e_q, tnew_e_d, md_start_e_q, md_start_e_d;
    logic [4:0] wa_m_q, wa_m_d, rt_m_q, rt_m_d;
    logic [1:0] res_m_q, res_m_d, tnew_m_q, tnew_m_d;
    logic [4:0] wa_w_q, wa_w_d;
    logic [1:0] res_w_q, res_w_d;
    logic [3:0] busy_q, busy_d;
    logic       stall_rs, stall_rt, stall_md;

    function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] wa_e, input logic [1:0] tnew_e,
                                        input logic [4:0] wa_m, input logic [1:0] tnew_m);
        return (src != 5'd0) && (tuse != 2'd3) &&
               (((src == wa_e) && (tnew_e > tuse)) || ((src == wa_m) && (tnew_m > tuse)));
    endfunction

    // M wins over W; an M producer only forwards once its ALU/PC result exists.
    function automatic logic [3:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] wa_m, input logic [1:0] res_m,
                                           input logic [1:0] tnew_m,
                                           input logic [4:0] wa_w, input logic [1:0] res_w);
        logic [3:0] sel;
        sel = 4'd0;
        if ((src != 5'd0) && (src == wa_m) && (tnew_m == 2'd0) &&
            ((res_m == RES_ALU) || (res_m == RES_PC))) begin
            sel = (res_m == RES_ALU) ? 4'd1 : 4'd2;
        end else if ((src != 5'd0) && (src == wa_w) && (res_w != RES_NONE)) begin
            case (res_w)
                RES_ALU: sel = 4'd3;
                RES_DM:  sel = 4'd4;
                default: sel = 4'd5;
            endcase
        end
        return sel;
    endfunction

    always_comb begin
        md_busy  = (busy_q != 4'd0) || (md_start_e_q != 2'd0);
        stall_rs = src_hazard(rs_D, tuse_rs_D, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q);
        stall_rt = src_hazard(rt_D, tuse_rt_D, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q);
        stall_md = md_D && md_busy;
        stall    = stall_rs || stall_rt || stall_md;

        sel_cmp1_D = fwd_sel(rs_D,   wa_m_q, res_m_q, tnew_m_q, wa_w_q, res_w_q);
        sel_cmp2_D = fwd_sel(rt_D,   wa_m_q, res_m_q, tnew_m_q, wa_w_q, res_w_q);
        sel_alua_E = fwd_sel(rs_e_q, wa_m_q, res_m_q, tnew_m_q, wa_w_q, res_w_q);
        sel_alub_E = fwd_sel(rt_e_q, wa_m_q, res_m_q, tnew_m_q, wa_w_q, res_w_q);

        sel_dm_M = 4'd0;
        if ((rt_m_q != 5'd0) && (rt_m_q == wa_w_q) && (res_w_q != RES_NONE)) begin
            sel_dm_M = {2'b00, res_w_q};
        end
    end

    always_comb begin
        wa_w_d   = wa_m_q;
        res_w_d  = res_m_q;
        wa_m_d   = wa_e_q;
        res_m_d  = res_e_q;
        rt_m_d   = rt_e_q;
        tnew_m_d = (tnew_e_q != 2'd0) ? tnew_e_q - 2'd1 : 2'd0;

        wa_e_d       = 5'd0;
        res_e_d      = RES_NONE;
        tnew_e_d     = 2'd0;
        rs_e_d       = 5'd0;
        rt_e_d       = 5'd0;
        md_start_e_d = 2'd0;
        if (!stall) begin
            wa_e_d       = wa_D;
            res_e_d      = res_D;
            rs_e_d       = rs_D;
            rt_e_d       = rt_D;
            md_start_e_d = md_start_D;
            case (res_D)
                RES_ALU, RES_PC: tnew_e_d = 2'd1;
                RES_DM:          tnew_e_d = 2'd2;
                default:         tnew_e_d = 2'd0;
            endcase
        end

        // The counter covers the cycles after the start leaves E; E itself flags busy.
        case (md_start_e_q)
            2'd1:    busy_d = MULT_CYC;
            2'd2:    busy_d = DIV_CYC;
            default: busy_d = (busy_q != 4'd0) ? busy_q - 4'd1 : 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wa_e_q       <= '0;
            res_e_q      <= '0;
            tnew_e_q     <= '0;
            rs_e_q       <= '0;
            rt_e_q       <= '0;
            md_start_e_q <= '0;
            wa_m_q       <= '0;
            res_m_q      <= '0;
            tnew_m_q     <= '0;
            rt_m_q       <= '0;
            wa_w_q       <= '0;
            res_w_q      <= '0;
            busy_q       <= '0;
        end else begin
            wa_e_q       <= wa_e_d;
            res_e_q      <= res_e_d;
            tnew_e_q     <= tnew_e_d;
            rs_e_q       <= rs_e_d;
            rt_e_q       <= rt_e_d;
            md_start_e_q <= md_start_e_d;
            wa_m_q       <= wa_m_d;
            res_m_q      <= res_m_d;
            tnew_m_q     <= tnew_m_d;
            rt_m_q       <= rt_m_d;
            wa_w_q       <= wa_w_d;
            res_w_q      <= res_w_d;
            busy_q       <= busy_d;
        end
    end

endmodule
